// File: rtl/mac_ctrl_if.sv
// mac_ctrl_if: operand-in, multiplier and result-out bus of the mac_ctrl sequencer
//   in_valid/in_ready/in_a/in_b/in_last         operand pair stream
//   mul_a_i/mul_b_i/mul_start/mul_busy/mul_result  start/busy link to the sequential multiplier
//   acc_valid/acc_ready/acc_out/acc_count/acc_err  dot-product result stream
//   busy                                          sequencer not idle
//   slave = mac_ctrl side, master = environment side
interface mac_ctrl_if #(parameter int ACC_W = 24, parameter int CNT_W = 10);
  logic in_valid, in_ready, in_last;
  logic [7:0] in_a, in_b, mul_a_i, mul_b_i;
  logic mul_start, mul_busy;
  logic [15:0] mul_result;
  logic acc_valid, acc_ready, acc_err, busy;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_count;
  modport slave(
    input in_valid, in_a, in_b, in_last, mul_busy, mul_result, acc_ready,
    output in_ready, mul_a_i, mul_b_i, mul_start, acc_valid, acc_out, acc_count, acc_err, busy
  );
  modport master(
    output in_valid, in_a, in_b, in_last, mul_busy, mul_result, acc_ready,
    input in_ready, mul_a_i, mul_b_i, mul_start, acc_valid, acc_out, acc_count, acc_err, busy
  );
endinterface

// File: rtl/mac_ctrl.sv
// mac_ctrl: multiply-accumulate sequencer feeding a start/busy 8x8 multiplier
//   clk, rst : clock, synchronous active-high reset
//   ifc      : mac_ctrl_if.slave (operand stream in, multiplier link, result stream out)
//   MAC_SATURATE_EN defined: accumulator clamps at all-ones and flags acc_err on overflow;
//   undefined: accumulator wraps and overflow is not reported.
module mac_ctrl #(
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 2000
) (
  input logic clk,
  input logic rst,
  mac_ctrl_if.slave ifc
);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic last_q, last_d, err_q, err_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout;
  logic [15:0] prod;
  logic [ACC_W:0] sum;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    last_d = last_q;
    err_d = err_q;
    wcnt_d = wcnt_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    timeout = wcnt_q == WC_W'(TIMEOUT - 1);
    // an abandoned multiply contributes zero
    prod = ifc.mul_busy ? 16'd0 : ifc.mul_result;
    sum = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
    case (state_q)
      IDLE: if (ifc.in_valid) begin
        a_d = ifc.in_a;
        b_d = ifc.in_b;
        last_d = ifc.in_last;
        state_d = ISSUE;
      end
      ISSUE: state_d = GAP;
      GAP: begin
        wcnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (!ifc.mul_busy || timeout) begin
`ifdef MAC_SATURATE_EN
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        err_d = err_q | ifc.mul_busy | sum[ACC_W];
`else
        acc_d = sum[ACC_W-1:0];
        err_d = err_q | ifc.mul_busy;
`endif
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = last_q ? DONE : IDLE;
      end else wcnt_d = wcnt_q + 1'b1;
      DONE: if (ifc.acc_ready) begin
        acc_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      wcnt_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      last_q <= last_d;
      err_q <= err_d;
      wcnt_q <= wcnt_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign ifc.in_ready = !rst && state_q == IDLE;
  assign ifc.mul_a_i = a_q;
  assign ifc.mul_b_i = b_q;
  assign ifc.mul_start = state_q == ISSUE;
  assign ifc.acc_valid = state_q == DONE;
  assign ifc.acc_out = acc_q;
  assign ifc.acc_count = cnt_q;
  assign ifc.acc_err = err_q;
  assign ifc.busy = state_q != IDLE;
endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: randomized scoreboard bench for mac_ctrl with a behavioural multiplier stub
module tb_mac_ctrl;
  localparam int ACC_W = 24, CNT_W = 10, TO = 2000;
  typedef struct {logic [ACC_W-1:0] sum; logic [CNT_W-1:0] cnt; logic err;} exp_t;
  typedef struct {int late; int lat; bit hang;} cfg_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mac_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) ifc();
  mac_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .TIMEOUT(TO)) dut(.clk(clk), .rst(rst), .ifc(ifc));
  exp_t q[$];
  cfg_t cq[$];
  int n_vec = 0, n_err = 0, start_cycles = 0;
  int va[300], vb[300];
  bit vh[300];
  bit hold_rdy = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  // multiplier stub: busy optionally one cycle late, product after lat cycles, or never when hung
  initial begin
    cfg_t c;
    int t;
    bit pend;
    logic [7:0] pa, pb;
    pend = 0;
    t = 0;
    pa = 0;
    pb = 0;
    c.late = 0;
    c.lat = 3;
    c.hang = 0;
    ifc.mul_busy = 0;
    ifc.mul_result = 0;
    forever begin
      @(negedge clk);
      if (ifc.mul_start) begin
        start_cycles++;
        if (cq.size() != 0) c = cq.pop_front();
        else begin
          c.late = 0;
          c.lat = 3;
          c.hang = 0;
        end
        pend = 1;
        t = 0;
        pa = ifc.mul_a_i;
        pb = ifc.mul_b_i;
      end else if (pend) t++;
      if (pend) begin
        if (!c.hang && t >= c.late + c.lat) begin
          pend = 0;
          ifc.mul_busy = 0;
          ifc.mul_result = {8'd0, pa} * {8'd0, pb};
        end else ifc.mul_busy = t >= c.late;
      end
    end
  end
  // monitor: pops an expectation when a result appears, rechecks it while it is held
  initial begin
    exp_t cur;
    bit held, exp_idle;
    held = 0;
    exp_idle = 0;
    cur.sum = 0;
    cur.cnt = 0;
    cur.err = 0;
    ifc.acc_ready = 0;
    forever begin
      @(negedge clk);
      if (exp_idle) begin
        chk("idle_after_ack", {ifc.busy, ifc.acc_valid}, 0);
        exp_idle = 0;
      end
      if (ifc.acc_valid) begin
        if (!held) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got acc_out %0d, want no result", ifc.acc_out);
          end else begin
            cur = q.pop_front();
            held = 1;
          end
        end
        if (held) begin
          chk("acc_out", ifc.acc_out, cur.sum);
          chk("acc_count", ifc.acc_count, cur.cnt);
          chk("acc_err", ifc.acc_err, cur.err);
          chk("in_ready_in_done", ifc.in_ready, 0);
        end
        ifc.acc_ready = hold_rdy ? 1'b0 : $urandom_range(0, 2) == 0;
        if (ifc.acc_ready) begin
          exp_idle = 1;
          held = 0;
        end
      end else ifc.acc_ready = 1'($urandom_range(0, 1));
    end
  end
  task automatic send(input int a, input int b, input bit last, input cfg_t c);
    int g = 0;
    cq.push_back(c);
    ifc.in_valid = 1;
    ifc.in_a = 8'(a);
    ifc.in_b = 8'(b);
    ifc.in_last = last;
    while (!ifc.in_ready && g < 3 * TO) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3 * TO) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0, want 1");
    end
    @(negedge clk);
    ifc.in_valid = 0;
  endtask
  // reference: dot product of the pairs, hung pairs count as zero and set the error
  task automatic run_vec(input int n);
    exp_t e;
    cfg_t c;
    longint s = 0, mx = (longint'(1) << ACC_W) - 1, p;
    bit err = 0;
    for (int i = 0; i < n; i++) begin
      p = vh[i] ? 0 : longint'(va[i] * vb[i]);
      err |= vh[i];
`ifdef MAC_SATURATE_EN
      if (s + p > mx) begin
        s = mx;
        err = 1;
      end else s += p;
`else
      s = (s + p) & mx;
`endif
    end
    e.sum = ACC_W'(s);
    e.cnt = n > (1 << CNT_W) - 1 ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(n);
    e.err = err;
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      c.late = $urandom_range(0, 1);
      c.lat = $urandom_range(3, 6);
      c.hang = vh[i];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(va[i], vb[i], i == n - 1, c);
    end
  endtask
  task automatic wait_done();
    int g = 0;
    while ((q.size() != 0 || ifc.busy) && g < 6 * TO) begin
      @(negedge clk);
      g++;
    end
    if (g >= 6 * TO) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got queue %0d busy %0b, want 0 0", q.size(), ifc.busy);
    end
  endtask
  initial begin
    cfg_t c;
    int g;
    ifc.in_valid = 0;
    ifc.in_a = 0;
    ifc.in_b = 0;
    ifc.in_last = 0;
    for (int i = 0; i < 300; i++) vh[i] = 0;
    repeat (3) @(negedge clk);
    chk("in_ready_in_rst", ifc.in_ready, 0);
    rst = 0;
    #1;
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_acc_valid", ifc.acc_valid, 0);
    chk("rst_acc_out", ifc.acc_out, 0);
    chk("rst_acc_count", ifc.acc_count, 0);
    chk("rst_acc_err", ifc.acc_err, 0);
    chk("rst_mul_start", ifc.mul_start, 0);
    chk("rst_mul_ab", {ifc.mul_a_i, ifc.mul_b_i}, 0);
    @(negedge clk);
    start_cycles = 0;
    va[0] = 3; vb[0] = 2; va[1] = 5; vb[1] = 5; va[2] = 4; vb[2] = 3;
    run_vec(3);
    wait_done();
    chk("start_pulse_cycles", start_cycles, 3);
    va[0] = 255; vb[0] = 255;
    run_vec(1);
    va[0] = 255; vb[0] = 0;
    run_vec(1);
    for (int i = 0; i < 259; i++) begin
      va[i] = 255;
      vb[i] = 255;
    end
    run_vec(259);
    wait_done();
    c.late = 0;
    c.lat = 3;
    c.hang = 0;
    send(3, 4, 0, c);
    c.lat = 6;
    send(5, 6, 0, c);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("in_ready_mid_rst", ifc.in_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_in_ready", ifc.in_ready, 1);
    chk("post_rst_acc_out", ifc.acc_out, 0);
    chk("post_rst_acc_count", ifc.acc_count, 0);
    chk("post_rst_busy", ifc.busy, 0);
    @(negedge clk);
    va[0] = 3; vb[0] = 2;
    run_vec(1);
    wait_done();
    hold_rdy = 1;
    va[0] = 17; vb[0] = 9; va[1] = 200; vb[1] = 100;
    run_vec(2);
    g = 0;
    while (!ifc.acc_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("hold_reached_done", ifc.acc_valid, 1);
    repeat (10) @(negedge clk);
    hold_rdy = 0;
    wait_done();
    vh[0] = 1; va[0] = 7; vb[0] = 7; va[1] = 2; vb[1] = 3;
    run_vec(2);
    wait_done();
    vh[0] = 1; va[0] = 9; vb[0] = 9;
    run_vec(1);
    wait_done();
    vh[0] = 0;
    for (int v = 0; v < 25; v++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        va[i] = $urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, 255);
        vb[i] = $urandom_range(0, 255);
      end
      run_vec(n);
    end
    wait_done();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
